// File: rtl/if_pc_predict_if.sv
// Fetch-side bundle of if_pc_predict: stall and EX resolve inputs, fetch PC and prediction outputs.
interface if_pc_predict_if;
    logic        stallF;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_predicted;
    logic [31:0] res_pred_target;
    logic [31:0] PC_IF;
    logic        predict_taken;
    logic [31:0] pred_target;
    logic        flush_out;

    modport master (
        output stallF, res_valid, res_pc, res_taken, res_target, res_predicted, res_pred_target,
        input  PC_IF, predict_taken, pred_target, flush_out
    );

    modport slave (
        input  stallF, res_valid, res_pc, res_taken, res_target, res_predicted, res_pred_target,
        output PC_IF, predict_taken, pred_target, flush_out
    );
endinterface

// File: rtl/if_pc_predict.sv
// Fetch PC generator: EX redirect, stall hold, optional BTB prediction, else PC+4.
// Define IF_BTB_EN to build the direct-mapped BTB with 2-bit direction counters.
module if_pc_predict #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    localparam int         IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic           clk,
    input  logic           rst_n,
    if_pc_predict_if.slave bus
);
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic        predict_taken;
    logic [31:0] pred_target;
    logic        mispredict;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_BTB_EN
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [BTB_ENTRIES];
    logic [1:0]       ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [31:0]      target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_r;
    logic [TAG_W-1:0] tag_f;
    logic [TAG_W-1:0] tag_r;
    logic             hit_f;
    logic             hit_r;

    assign idx_f = pc_q[IDX_W+1:2];
    assign tag_f = pc_q[31:IDX_W+2];
    assign idx_r = bus.res_pc[IDX_W+1:2];
    assign tag_r = bus.res_pc[31:IDX_W+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_r = valid_q[idx_r] && (tag_q[idx_r] == tag_r);

    assign predict_taken = hit_f && ctr_q[idx_f][1];
    assign pred_target   = hit_f ? target_q[idx_f] : pc_plus4;
    assign mispredict    = bus.res_valid &&
                           ((bus.res_taken != bus.res_predicted) ||
                            (bus.res_taken && bus.res_predicted &&
                             (bus.res_target != bus.res_pred_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (bus.res_valid) begin
            if (hit_r) begin
                if (bus.res_taken && (ctr_q[idx_r] != 2'b11))
                    ctr_q[idx_r] <= ctr_q[idx_r] + 2'd1;
                else if (!bus.res_taken && (ctr_q[idx_r] != 2'b00))
                    ctr_q[idx_r] <= ctr_q[idx_r] - 2'd1;
            end else if (bus.res_taken) begin
                valid_q[idx_r] <= 1'b1;
                ctr_q[idx_r]   <= 2'b10;
            end
        end
    end

    // Tag/target are gated by valid, so no reset; a taken hit rewrites an identical tag.
    always_ff @(posedge clk) begin
        if (bus.res_valid && bus.res_taken) begin
            tag_q[idx_r]    <= tag_r;
            target_q[idx_r] <= bus.res_target;
        end
    end
`else
    logic unused_ok;

    assign predict_taken = 1'b0;
    assign pred_target   = pc_plus4;
    assign mispredict    = bus.res_valid && bus.res_taken;
    assign unused_ok     = ^{bus.res_predicted, bus.res_pred_target, pc_q[IDX_W+1:2]};
`endif

    always_comb begin
        pc_d = pc_plus4;
        if (mispredict)
            pc_d = bus.res_taken ? bus.res_target : (bus.res_pc + 32'd4);
        else if (bus.stallF)
            pc_d = pc_q;
        else if (predict_taken)
            pc_d = pred_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign bus.PC_IF         = pc_q;
    assign bus.predict_taken = predict_taken;
    assign bus.pred_target   = pred_target;
    assign bus.flush_out     = mispredict;
endmodule

// File: tb/tb_if_pc_predict.sv
// Bench for if_pc_predict: directed loop/stall/alias/wrap vectors plus a random tail, checked
// every cycle against a word-address BTB model and at key points against literal values.
module tb_if_pc_predict;
`ifdef IF_BTB_EN
    localparam bit P = 1'b1;
`else
    localparam bit P = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          N      = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_pc_predict_if b();
    if_pc_predict #(.RESET_PC(RST_PC), .BTB_ENTRIES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each slot remembers the full word address of the branch that owns it.
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_owner [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    bit          p_en, p_wr;
    int          p_i, p_ctr;
    logic [31:0] p_pc, p_owner, p_tgt;

    function automatic int slot(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(N));
    endfunction

    function automatic bit owns(input int s, input logic [31:0] a);
        return m_valid[s] && ((m_owner[s] / 32'(4 * N)) == (a / 32'(4 * N)));
    endfunction

    always @(negedge clk) begin : model_check
        int          s, r;
        bit          hit, e_pt, e_mis;
        logic [31:0] e_ptg, e_next;
        if (!rst_n) begin
            m_pc = RST_PC;
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
        end
        s     = slot(m_pc);
        hit   = P && owns(s, m_pc);
        e_pt  = hit && (m_ctr[s] >= 2);
        e_ptg = hit ? m_tgt[s] : m_pc + 32'd4;
        e_mis = b.res_valid && (P ? ((b.res_taken != b.res_predicted) ||
                                     (b.res_taken && b.res_predicted && b.res_target != b.res_pred_target))
                                  : b.res_taken);
        chk("mdl_pc",    b.PC_IF,         m_pc);
        chk("mdl_pt",    b.predict_taken, 32'(e_pt));
        chk("mdl_ptg",   b.pred_target,   e_ptg);
        chk("mdl_flush", b.flush_out,     32'(e_mis));
        if (e_mis)         e_next = b.res_taken ? b.res_target : b.res_pc + 32'd4;
        else if (b.stallF) e_next = m_pc;
        else if (e_pt)     e_next = e_ptg;
        else               e_next = m_pc + 32'd4;
        p_wr = 1'b0;
        if (P && b.res_valid) begin
            r = slot(b.res_pc);
            if (owns(r, b.res_pc)) begin
                p_wr    = 1'b1;
                p_i     = r;
                p_owner = b.res_pc;
                p_tgt   = b.res_taken ? b.res_target : m_tgt[r];
                p_ctr   = b.res_taken ? ((m_ctr[r] < 3) ? m_ctr[r] + 1 : 3)
                                      : ((m_ctr[r] > 0) ? m_ctr[r] - 1 : 0);
            end else if (b.res_taken) begin
                p_wr    = 1'b1;
                p_i     = r;
                p_owner = b.res_pc;
                p_tgt   = b.res_target;
                p_ctr   = 2;
            end
        end
        p_pc = e_next;
        p_en = rst_n;
    end

    always @(posedge clk) begin
        if (rst_n && p_en) begin
            m_pc <= p_pc;
            if (p_wr) begin
                m_valid[p_i] <= 1'b1;
                m_owner[p_i] <= p_owner;
                m_tgt[p_i]   <= p_tgt;
                m_ctr[p_i]   <= p_ctr;
            end
        end
    end

    task automatic drive(input bit st, input bit rv, input logic [31:0] rpc, input bit rt,
                         input logic [31:0] rtg, input bit rp, input logic [31:0] rptg);
        b.stallF          = st;
        b.res_valid       = rv;
        b.res_pc          = rpc;
        b.res_taken       = rt;
        b.res_target      = rtg;
        b.res_predicted   = rp;
        b.res_pred_target = rptg;
    endtask
    task automatic nop();  drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0); endtask
    task automatic res(input logic [31:0] rpc, input bit rt, input logic [31:0] rtg,
                       input bit rp, input logic [31:0] rptg);
        drive(1'b0, 1'b1, rpc, rt, rtg, rp, rptg);
    endtask
    task automatic settle(); #2; endtask
    task automatic tick();   @(posedge clk); #1; endtask

    initial begin
        nop();
        rst_n = 1'b0;
        repeat (2) tick();
        settle();
        chk("rst_pc", b.PC_IF, RST_PC);
        chk("rst_pt", b.predict_taken, 32'd0);
        chk("rst_ptg", b.pred_target, 32'h104);
        chk("rst_flush", b.flush_out, 32'd0);
        tick();
        rst_n = 1'b1;
        // sequential fetch after release
        nop(); settle(); chk("a0_pc", b.PC_IF, 32'h100); chk("a0_pt", b.predict_taken, 32'd0); tick();
        nop(); settle(); chk("a1_pc", b.PC_IF, 32'h104); tick();
        nop(); settle(); chk("a2_pc", b.PC_IF, 32'h108); tick();
        res(32'h10C, 1, 32'h100, 0, 32'h0); settle();
        chk("a3_pc", b.PC_IF, 32'h10C); chk("a3_pt", b.predict_taken, 32'd0); chk("a3_flush", b.flush_out, 32'd1); tick();
        nop(); settle(); chk("a4_pc", b.PC_IF, 32'h100); tick();
        nop(); tick(); nop(); tick();
        res(32'h10C, 1, 32'h100, P, 32'h100); settle();
        chk("a7_pc", b.PC_IF, 32'h10C); chk("a7_pt", b.predict_taken, 32'(P));
        chk("a7_ptg", b.pred_target, P ? 32'h100 : 32'h110); chk("a7_flush", b.flush_out, 32'(!P)); tick();
        nop(); settle(); chk("a8_pc", b.PC_IF, 32'h100); tick();
        nop(); tick(); nop(); tick();
        res(32'h10C, 1, 32'h100, P, 32'h100); settle(); chk("a11_flush", b.flush_out, 32'(!P)); tick();
        nop(); tick(); nop(); tick(); nop(); tick();
        res(32'h10C, 1, 32'h100, P, 32'h100); tick();
        nop(); tick(); nop(); tick(); nop(); tick();
        // direction turns not-taken
        res(32'h10C, 0, 32'h0, P, 32'h100); settle();
        chk("a19_pc", b.PC_IF, 32'h10C); chk("a19_pt", b.predict_taken, 32'(P)); chk("a19_flush", b.flush_out, 32'(P)); tick();
        res(32'h300, 1, 32'h10C, 0, 32'h0); settle(); chk("a20_pc", b.PC_IF, 32'h110); chk("a20_flush", b.flush_out, 32'd1); tick();
        res(32'h10C, 0, 32'h0, P, 32'h100); settle();
        chk("a21_pc", b.PC_IF, 32'h10C); chk("a21_pt", b.predict_taken, 32'(P)); tick();
        res(32'h300, 1, 32'h10C, 0, 32'h0); settle(); chk("a22_pc", b.PC_IF, 32'h110); tick();
        nop(); settle();
        chk("a23_pc", b.PC_IF, 32'h10C); chk("a23_pt", b.predict_taken, 32'd0);
        chk("a23_ptg", b.pred_target, P ? 32'h100 : 32'h110); tick();
        // stall hold, then redirect beats stall
        res(32'h400, 1, 32'h200, 0, 32'h0); settle(); chk("a24_pc", b.PC_IF, 32'h110); tick();
        drive(1, 0, 32'h0, 0, 32'h0, 0, 32'h0); settle(); chk("a25_pc", b.PC_IF, 32'h200); tick();
        drive(1, 0, 32'h0, 0, 32'h0, 0, 32'h0); settle(); chk("a26_pc", b.PC_IF, 32'h200); tick();
        drive(1, 1, 32'h500, 1, 32'h40, 0, 32'h0); settle();
        chk("a27_pc", b.PC_IF, 32'h200); chk("a27_flush", b.flush_out, 32'd1); tick();
        drive(1, 0, 32'h0, 0, 32'h0, 0, 32'h0); settle(); chk("a28_pc", b.PC_IF, 32'h40); tick();
        // aliasing at slot 3
        res(32'h10C, 1, 32'h100, 0, 32'h0); settle(); chk("a29_pc", b.PC_IF, 32'h40); tick();
        res(32'h700, 1, 32'h50C, 0, 32'h0); settle(); chk("a30_pc", b.PC_IF, 32'h100); tick();
        res(32'h50C, 1, 32'h600, 0, 32'h0); settle();
        chk("a31_pc", b.PC_IF, 32'h50C); chk("a31_pt", b.predict_taken, 32'd0); chk("a31_ptg", b.pred_target, 32'h510); tick();
        res(32'h800, 1, 32'h10C, 0, 32'h0); settle(); chk("a32_pc", b.PC_IF, 32'h600); tick();
        res(32'h900, 1, 32'h50C, 0, 32'h0); settle();
        chk("a33_pc", b.PC_IF, 32'h10C); chk("a33_pt", b.predict_taken, 32'd0); chk("a33_ptg", b.pred_target, 32'h110); tick();
        nop(); settle();
        chk("a34_pc", b.PC_IF, 32'h50C); chk("a34_pt", b.predict_taken, 32'(P));
        chk("a34_ptg", b.pred_target, P ? 32'h600 : 32'h510); tick();
        // predicted-taken with wrong then right target
        res(32'h50C, 1, 32'h700, P, 32'h600); settle();
        chk("a35_pc", b.PC_IF, P ? 32'h600 : 32'h510); chk("a35_flush", b.flush_out, 32'd1); tick();
        res(32'h50C, 1, 32'h700, P, 32'h700); settle();
        chk("a36_pc", b.PC_IF, 32'h700); chk("a36_flush", b.flush_out, 32'(!P)); tick();
        // reset mid-operation discards the in-flight resolve
        res(32'h10C, 1, 32'h200, 0, 32'h0); rst_n = 1'b0; settle();
        chk("r0_pc", b.PC_IF, RST_PC); chk("r0_pt", b.predict_taken, 32'd0); chk("r0_flush", b.flush_out, 32'd1); tick();
        rst_n = 1'b1; nop(); settle(); chk("r1_pc", b.PC_IF, RST_PC); tick();
        res(32'hA00, 1, 32'h50C, 0, 32'h0); settle(); chk("r2_pc", b.PC_IF, 32'h104); tick();
        res(32'hB00, 1, 32'hFFFF_FFFC, 0, 32'h0); settle();
        chk("r3_pc", b.PC_IF, 32'h50C); chk("r3_pt", b.predict_taken, 32'd0); tick();
        nop(); settle(); chk("w0_pc", b.PC_IF, 32'hFFFF_FFFC); tick();
        nop(); settle(); chk("w1_pc", b.PC_IF, 32'h0); tick();
        // random tail, checked by the model only
        for (int n = 0; n < 300; n++) begin
            logic [31:0] tg;
            tg = 32'($urandom_range(0, 127)) * 32'd4;
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  32'($urandom_range(0, 127)) * 32'd4, 1'($urandom_range(0, 1)), tg,
                  P && ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1) ? tg : 32'($urandom_range(0, 127)) * 32'd4);
            tick();
        end
        nop();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
